// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder_scan block.
package decoder_pkg;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_t;

    // Widest one-hot vector the helper can build; the decoder limits IN_W to 8.
    localparam int MAX_OUT_W = 256;

    function automatic logic [MAX_OUT_W-1:0] onehot_of(input int idx);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_prescaler.sv
// Scan slot prescaler: counts 0..DIV-1 while not cleared and flags the last count of each slot.
module scan_prescaler #(
    parameter  int DIV = 1000,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tick
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick  = !clr && (count_q == CW'(DIV - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary to one-hot/one-cold decoder with valid/ready handshake and autonomous scan.
// Define DECODER_SCAN_BLANK_EN to blank the outputs for BLANK_CYC cycles at each scan slot start.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter  int IN_W      = 4,
    parameter  int SCAN_DIV  = 1000,
    parameter  int BLANK_CYC = 8,
    localparam int OUT_W     = 2 ** IN_W,
    localparam int CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scanMode,
    input  logic [IN_W-1:0]  scanLast,
    input  logic             inValid,
    output logic             inReady,
    input  logic [IN_W-1:0]  dataIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [OUT_W-1:0] oneHot,
    output logic [OUT_W-1:0] oneCold,
    output logic [IN_W-1:0]  index,
    output logic             slotTick
);

`ifdef DECODER_SCAN_BLANK_EN
    localparam int BLANK_EFF = BLANK_CYC;
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("decoder_scan: BLANK_CYC must be below SCAN_DIV");
    end
`else
    localparam int BLANK_EFF = 0;
`endif

    if (SCAN_DIV < 2 || BLANK_CYC < 0 || IN_W < 1 || IN_W > 8) begin : g_bad_param
        $error("decoder_scan: parameter out of range");
    end

    dec_state_t       state_q, state_d;
    logic [IN_W-1:0]  index_q, index_d;
    logic [OUT_W-1:0] one_hot_q, one_hot_d;
    logic             out_valid_q, out_valid_d;
    logic             slot_tick_q, slot_tick_d;

    logic [CW-1:0]    scan_count;
    logic             scan_tick;
    logic             scan_run;
    logic             accept;
    logic             enter_scan;
    logic             blank_d;
    int               scan_pos_d;

    assign scan_run = (state_q == SCAN) && scanMode;

    scan_prescaler #(
        .DIV   (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_run),
        .count (scan_count),
        .tick  (scan_tick)
    );

    // A pending scan request stops new accepts so an accepted item is never overwritten by scan entry.
    assign inReady = (state_q == DIRECT) && !scanMode && (!out_valid_q || outReady);
    assign accept  = inValid && inReady;

    // Slot position the prescaler will hold next cycle, so blanking lines up with the registered output.
    assign scan_pos_d = (scan_run && !scan_tick) ? int'(scan_count) + 1 : 0;
    assign blank_d    = scan_pos_d < BLANK_EFF;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        one_hot_d   = one_hot_q;
        out_valid_d = out_valid_q;
        slot_tick_d = 1'b0;
        enter_scan  = 1'b0;

        case (state_q)
            IDLE: begin
                if (scanMode) begin
                    enter_scan = 1'b1;
                end else begin
                    state_d = DIRECT;
                end
            end
            DIRECT: begin
                if (scanMode && (!out_valid_q || outReady)) begin
                    enter_scan = 1'b1;
                end else if (accept) begin
                    index_d     = dataIn;
                    one_hot_d   = OUT_W'(onehot_of(int'(dataIn)));
                    out_valid_d = 1'b1;
                end else if (outReady) begin
                    out_valid_d = 1'b0;
                end
            end
            SCAN: begin
                if (!scanMode) begin
                    state_d     = DIRECT;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                    if (scan_tick) begin
                        index_d     = (index_q >= scanLast) ? '0 : index_q + 1'b1;
                        slot_tick_d = 1'b1;
                    end
                    one_hot_d = blank_d ? '0 : OUT_W'(onehot_of(int'(index_d)));
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_scan) begin
            state_d     = SCAN;
            index_d     = '0;
            out_valid_d = 1'b1;
            one_hot_d   = blank_d ? '0 : OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            one_hot_q   <= '0;
            out_valid_q <= 1'b0;
            slot_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            one_hot_q   <= one_hot_d;
            out_valid_q <= out_valid_d;
            slot_tick_q <= slot_tick_d;
        end
    end

    assign oneHot   = one_hot_q;
    assign oneCold  = ~one_hot_q;
    assign index    = index_q;
    assign outValid = out_valid_q;
    assign slotTick = slot_tick_q;

endmodule
